// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over back-to-back GATE_CYCLES windows.
// Define FREQ_METER_LOCK_QUAL_EN to add a pll_locked input that qualifies enable.
module freq_meter #(
    parameter int GATE_CYCLES = 50000,
    parameter int WIDTH       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             enable,
`ifdef FREQ_METER_LOCK_QUAL_EN
    input  logic             pll_locked,
`endif
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [WIDTH-1:0] EDGE_MAX  = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sat_q, sat_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             edge_s;
    logic             run_s;

`ifdef FREQ_METER_LOCK_QUAL_EN
    logic lk1_q, lk2_q;

    // Two-flop synchronizer for the asynchronous lock indicator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk1_q <= 1'b0;
            lk2_q <= 1'b0;
        end else begin
            lk1_q <= pll_locked;
            lk2_q <= lk1_q;
        end
    end

    // Losing lock behaves exactly like dropping enable
    assign run_s = enable & lk2_q;
`else
    assign run_s = enable;
`endif

    assign edge_s = s2_q & ~s3_q;

    // Next-state and datapath logic for the gate/latch sequencer
    always_comb begin
        s1_d       = sig_in;
        s2_d       = s1_q;
        s3_d       = s2_q;
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        q_d        = q_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                if (run_s) begin
                    state_d = GATE;
                end else begin
                    state_d = IDLE;
                end
            end
            GATE: begin
                if (!run_s) begin
                    state_d    = IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else begin
                    if (edge_s && (edge_cnt_q == EDGE_MAX)) begin
                        sat_d = 1'b1;
                    end else if (edge_s) begin
                        edge_cnt_d = edge_cnt_q + WIDTH'(1);
                    end else begin
                        edge_cnt_d = edge_cnt_q;
                    end
                    // The final gate cycle still counts its own edge before latching
                    if (gate_cnt_q == GATE_LAST) begin
                        state_d = LATCH;
                    end else begin
                        gate_cnt_d = gate_cnt_q + GW'(1);
                    end
                end
            end
            LATCH: begin
                q_d        = edge_cnt_q;
                overflow_d = sat_q;
                valid_d    = 1'b1;
                gate_cnt_d = '0;
                sat_d      = 1'b0;
                // An edge seen while latching belongs to the following window
                if (run_s) begin
                    state_d    = GATE;
                    edge_cnt_d = edge_s ? WIDTH'(1) : WIDTH'(0);
                end else begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, synchronizer and registered-output flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            q_q        <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            q_q        <= q_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign q        = q_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000, gate window length in clk cycles (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter WIDTH, default 10, width of the result count q.
REQ-003 SHALL have port clk  input  1  system clock (CLOCK_50 domain); the block has exactly one clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sig_in  input  1  measured signal, asynchronous to clk (e.g. a counter bit from a PLL-clocked counter).
REQ-006 SHALL have port enable  input  1  level; 1 = run back-to-back gate windows.
REQ-007 SHALL have port q  output  WIDTH  rising-edge count of the last completed window.
REQ-008 SHALL have port valid  output  1  one-cycle pulse when q updates.
REQ-009 SHALL have port overflow  output  1  last completed window saturated.
REQ-010 SHALL have port busy  output  1  high while in GATE or LATCH state.

Function
REQ-011 SHALL synchronize sig_in through two flops (s1, s2) plus a history flop s3; a rising edge is s2=1 and s3=0.
REQ-012 SHALL have exactly three states: IDLE, GATE, LATCH.
REQ-013 IDLE: gate_cnt and edge_cnt held at 0; IDLE -> GATE on the first clk edge with enable=1.
REQ-014 GATE: gate_cnt increments each cycle from 0; each detected edge increments edge_cnt; GATE -> LATCH on the cycle gate_cnt = GATE_CYCLES-1 (that cycle's edge is counted).
REQ-015 GATE lasts exactly GATE_CYCLES cycles.
REQ-016 edge_cnt SHALL saturate at 2^WIDTH-1; further edges in the window set an internal sat flag.
REQ-017 LATCH (one cycle): q <= edge_cnt, overflow <= sat, valid=1; then GATE if enable=1, else IDLE.
REQ-018 An edge detected in the LATCH cycle SHALL be counted in the next window (edge_cnt loads 1, else 0); gate_cnt and sat are cleared.
REQ-019 enable dropping to 0 during GATE SHALL abort the window on the next clk edge: go to IDLE, q/overflow unchanged, no valid pulse.
REQ-020 valid SHALL never be high in two consecutive cycles.
REQ-021 busy = 1 in GATE and LATCH, 0 in IDLE.
REQ-022 sig_in-to-detection latency SHALL be 2–3 clk cycles; sig_in frequency must be below clk/2 for exact counts.

Reset
REQ-023 rst=1 SHALL asynchronously force: state IDLE, s1/s2/s3=0, gate_cnt=0, edge_cnt=0, sat=0, q=0, valid=0, overflow=0, busy=0.
REQ-024 Reset asserted mid-window SHALL discard the window with no valid pulse; after release, operation restarts from IDLE.

Configuration
REQ-025 Macro FREQ_METER_LOCK_QUAL_EN SHALL, when defined, add port pll_locked input 1 (asynchronous, synchronized by two flops internally).
REQ-026 With FREQ_METER_LOCK_QUAL_EN defined, synchronized pll_locked=0 SHALL be treated as enable=0 (abort/stay IDLE), and a window during which lock was lost SHALL never produce valid.
REQ-027 Without FREQ_METER_LOCK_QUAL_EN, the port SHALL not exist and behaviour is per REQ-011..REQ-024 only.

Verification (GATE_CYCLES=100, WIDTH=10)
REQ-028 SHALL cover: sig_in period 10 clk, enable=1 -> valid every 101 cycles, q=10 each window (±1 for phase), overflow=0.
REQ-029 SHALL cover: WIDTH=4, sig_in period 4 clk -> q=15, overflow=1.
REQ-030 SHALL cover: enable dropped at gate_cnt=50 -> no valid, q keeps previous value, busy=0 one cycle later.
REQ-031 SHALL cover: rst pulsed mid-window -> q=0, valid=0 immediately (asynchronous); the first valid arrives 101 cycles after the first enable-high edge following reset.
REQ-032 SHALL cover: sig_in held constant -> q=0, overflow=0; sig_in edge on the LATCH cycle -> counted in the next window (q=1 if no other edges).
REQ-033 SHALL cover, with FREQ_METER_LOCK_QUAL_EN: pll_locked=0 for 5 cycles mid-window -> no valid for that window; the next full window reports normally.
